ppi8255: RTL

Parametrised 8255-compatible programmable peripheral interface for the Atom bus, replacing the fixed-direction PIA at 0xB0xx. Direction and mode are programmed through the control register. Mode 0 provides plain I/O with per-group direction. Mode 1 provides strobed input/output handshakes on ports A and B, with port C carrying handshake and interrupt lines. It sits on the registered CPU bus (`clk_cpu` domain), and the keyboard, cassette and VDG connect to its port pins.

---
 rtl/ppi8255_pkg.sv | 41 ++++
 rtl/ppi8255_if.sv | 14 +
 rtl/ppi8255_handshake.sv | 107 ++++++++++
 rtl/ppi8255.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ppi8255_pkg.sv
// Shared constants for the ppi8255 peripheral: bus addresses, control-word
// bit positions, mode encoding, port C handshake pin map and reset control.
package ppi_pkg;

  // Register addresses
  localparam logic [1:0] ADDR_PA   = 2'b00;
  localparam logic [1:0] ADDR_PB   = 2'b01;
  localparam logic [1:0] ADDR_PC   = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  // Control-word bit positions (mode-set form)
  localparam int CW_MODE_SET  = 7;
  localparam int CW_A_MODE_HI = 6;
  localparam int CW_A_MODE_LO = 5;
  localparam int CW_A_IN      = 4;
  localparam int CW_CU_IN     = 3;
  localparam int CW_B_MODE    = 2;
  localparam int CW_B_IN      = 1;
  localparam int CW_CL_IN     = 0;

  typedef enum logic {
    MODE0 = 1'b0,
    MODE1 = 1'b1
  } ppi_mode_e;

  // Port C handshake pin map
  localparam logic [2:0] PC_STB_A  = 3'd4;
  localparam logic [2:0] PC_IBF_A  = 3'd5;
  localparam logic [2:0] PC_ACK_A  = 3'd6;
  localparam logic [2:0] PC_OBF_A  = 3'd7;
  localparam logic [2:0] PC_INTR_A = 3'd3;
  localparam logic [2:0] PC_STB_B  = 3'd2;
  localparam logic [2:0] PC_ACK_B  = 3'd2;
  localparam logic [2:0] PC_IBF_B  = 3'd1;
  localparam logic [2:0] PC_OBF_B  = 3'd1;
  localparam logic [2:0] PC_INTR_B = 3'd0;

  // Atom layout: PA out, PB in, PC[7:4] in, PC[3:0] out, mode 0
  localparam logic [7:0] DEFAULT_RESET_CONTROL = 8'h8A;

endpackage

// File: rtl/ppi8255_if.sv
// CPU-side register bus of the ppi8255.
// Handshake: an access happens in every clk cycle with enable=1; there is no
// ready/stall. rnw selects read (1) or write (0); dout is valid combinationally
// in the same cycle as addr, writes take effect on the closing clk edge.
interface ppi8255_if;
  logic       enable;
  logic       rnw;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output enable, rnw, addr, din, input dout);
  modport slave  (input enable, rnw, addr, din, output dout);
endinterface

// File: rtl/ppi8255_handshake.sv
// Mode 1 strobe/acknowledge handshake for one port group: synchroniser,
// edge detect and the IBF / OBF# / INTR / INTE state. Pin positions are
// parameters so one module serves both group A and group B.
module ppi_handshake
  import ppi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] STB_PIN     = PC_STB_A,
  parameter logic [2:0] ACK_PIN     = PC_ACK_A,
  parameter logic [2:0] IBF_PIN     = PC_IBF_A,
  parameter logic [2:0] OBF_PIN     = PC_OBF_A,
  parameter logic [2:0] INTR_PIN    = PC_INTR_A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       dir_in,
  input  logic       mode_set,
  input  logic       inte_wr,
  input  logic       inte_val,
  input  logic       port_rd,
  input  logic       port_wr,
  input  logic       stb_n,
  input  logic       ack_n,
  input  logic [7:0] port_in,
  output logic [7:0] in_latch,
  output logic [7:0] pc_val,
  output logic [7:0] pc_own,
  output logic [7:0] pc_inp
);
  // [SYNC_STAGES-1] is the newest synchronised sample, [SYNC_STAGES] the one before
  logic [SYNC_STAGES:0] stb_sync;
  logic [SYNC_STAGES:0] ack_sync;
  logic ibf, obf_n, intr, inte;
  logic stb_fall, stb_rise, ack_fall, ack_rise;

  // Synchronisers idle high so reset never looks like a strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      stb_sync <= '1;
      ack_sync <= '1;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-1:0], stb_n};
      ack_sync <= {ack_sync[SYNC_STAGES-1:0], ack_n};
    end
  end

  assign stb_fall = stb_sync[SYNC_STAGES] & ~stb_sync[SYNC_STAGES-1];
  assign stb_rise = ~stb_sync[SYNC_STAGES] & stb_sync[SYNC_STAGES-1];
  assign ack_fall = ack_sync[SYNC_STAGES] & ~ack_sync[SYNC_STAGES-1];
  assign ack_rise = ~ack_sync[SYNC_STAGES] & ack_sync[SYNC_STAGES-1];

  // Handshake state; a mode set clears it and discards any coincident edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ibf      <= 1'b0;
      obf_n    <= 1'b1;
      intr     <= 1'b0;
      inte     <= 1'b0;
      in_latch <= 8'h00;
    end else if (mode_set) begin
      ibf   <= 1'b0;
      obf_n <= 1'b1;
      intr  <= 1'b0;
      inte  <= 1'b0;
    end else begin
      if (inte_wr) inte <= inte_val;
      if (active && dir_in) begin
        // Strobe latches new data even when the CPU reads in the same cycle
        if (stb_fall) begin
          in_latch <= port_in;
          ibf      <= 1'b1;
        end else if (port_rd) begin
          ibf <= 1'b0;
        end
        if (port_rd) intr <= 1'b0;
        else if (stb_rise && inte) intr <= 1'b1;
      end else if (active) begin
        // CPU write beats a coincident acknowledge
        if (port_wr) obf_n <= 1'b0;
        else if (ack_fall) obf_n <= 1'b1;
        if (port_wr) intr <= 1'b0;
        else if (ack_rise && inte) intr <= 1'b1;
      end
    end
  end

  // Port C overlay: which pins this group drives, their values, and which pins it listens to
  always_comb begin
    pc_val = 8'h00;
    pc_own = 8'h00;
    pc_inp = 8'h00;
    if (active) begin
      pc_own[INTR_PIN] = 1'b1;
      pc_val[INTR_PIN] = intr;
      if (dir_in) begin
        pc_own[IBF_PIN] = 1'b1;
        pc_val[IBF_PIN] = ibf;
        pc_inp[STB_PIN] = 1'b1;
      end else begin
        pc_own[OBF_PIN] = 1'b1;
        pc_val[OBF_PIN] = obf_n;
        pc_inp[ACK_PIN] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ppi8255.sv
// 8255-compatible programmable peripheral interface for the Atom bus.
// Define PPI_MODE1_EN to build the mode 1 strobed handshakes; without it the
// mode fields are stored but ignored and no handshake logic is built.
module ppi8255
  import ppi_pkg::*;
#(
  parameter logic [7:0] RESET_CONTROL = DEFAULT_RESET_CONTROL,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  ppi8255_if.slave   bus,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pc_out,
  output logic [7:0] pa_oe,
  output logic [7:0] pb_oe,
  output logic [7:0] pc_oe
);
  logic [7:0] ctrl, pa_lat, pb_lat, pc_lat;
  logic [7:0] base_pc_oe, pa_rd, pb_rd, pc_rd;
  logic       wr, mode_set, bsr, a_in, b_in, inte_a_wr, inte_b_wr;
  logic [2:0] bsr_bit;
  ppi_mode_e  a_mode, b_mode;

  assign wr       = bus.enable & ~bus.rnw;
  assign mode_set = wr && (bus.addr == ADDR_CTRL) && bus.din[CW_MODE_SET];
  assign bsr      = wr && (bus.addr == ADDR_CTRL) && !bus.din[CW_MODE_SET];
  assign bsr_bit  = bus.din[3:1];
  assign a_in     = ctrl[CW_A_IN];
  assign b_in     = ctrl[CW_B_IN];

`ifdef PPI_MODE1_EN
  assign a_mode = (ctrl[CW_A_MODE_HI:CW_A_MODE_LO] != 2'b00) ? MODE1 : MODE0;
  assign b_mode = ctrl[CW_B_MODE] ? MODE1 : MODE0;
`else
  assign a_mode = MODE0;
  assign b_mode = MODE0;
`endif

  // BSR of a strobe/acknowledge pin in mode 1 programs INTE instead of the latch
  assign inte_a_wr = bsr && (a_mode == MODE1) &&
                     ((a_in && bsr_bit == PC_STB_A) || (!a_in && bsr_bit == PC_ACK_A));
  assign inte_b_wr = bsr && (b_mode == MODE1) && (bsr_bit == PC_STB_B);

  // Control register and output latches
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl   <= RESET_CONTROL;
      pa_lat <= 8'h00;
      pb_lat <= 8'h00;
      pc_lat <= 8'h00;
    end else if (mode_set) begin
      ctrl   <= bus.din;
      pa_lat <= 8'h00;
      pb_lat <= 8'h00;
      pc_lat <= 8'h00;
    end else if (wr) begin
      case (bus.addr)
        ADDR_PA: pa_lat <= bus.din;
        ADDR_PB: pb_lat <= bus.din;
        ADDR_PC: pc_lat <= bus.din;
        default: if (!inte_a_wr && !inte_b_wr) pc_lat[bsr_bit] <= bus.din[0];
      endcase
    end
  end

  assign pa_out     = pa_lat;
  assign pb_out     = pb_lat;
  assign pa_oe      = {8{~a_in}};
  assign pb_oe      = {8{~b_in}};
  assign base_pc_oe = {{4{~ctrl[CW_CU_IN]}}, {4{~ctrl[CW_CL_IN]}}};

`ifdef PPI_MODE1_EN
  logic       rd;
  logic [7:0] a_latch, a_pc_val, a_pc_own, a_pc_inp;
  logic [7:0] b_latch, b_pc_val, b_pc_own, b_pc_inp;

  assign rd = bus.enable & bus.rnw;

  ppi_handshake #(
    .SYNC_STAGES(SYNC_STAGES), .STB_PIN(PC_STB_A), .ACK_PIN(PC_ACK_A),
    .IBF_PIN(PC_IBF_A), .OBF_PIN(PC_OBF_A), .INTR_PIN(PC_INTR_A)
  ) u_hs_a (
    .clk(clk), .reset(reset), .active(a_mode == MODE1), .dir_in(a_in),
    .mode_set(mode_set), .inte_wr(inte_a_wr), .inte_val(bus.din[0]),
    .port_rd(rd && bus.addr == ADDR_PA), .port_wr(wr && bus.addr == ADDR_PA),
    .stb_n(pc_in[PC_STB_A]), .ack_n(pc_in[PC_ACK_A]), .port_in(pa_in),
    .in_latch(a_latch), .pc_val(a_pc_val), .pc_own(a_pc_own), .pc_inp(a_pc_inp)
  );

  ppi_handshake #(
    .SYNC_STAGES(SYNC_STAGES), .STB_PIN(PC_STB_B), .ACK_PIN(PC_ACK_B),
    .IBF_PIN(PC_IBF_B), .OBF_PIN(PC_OBF_B), .INTR_PIN(PC_INTR_B)
  ) u_hs_b (
    .clk(clk), .reset(reset), .active(b_mode == MODE1), .dir_in(b_in),
    .mode_set(mode_set), .inte_wr(inte_b_wr), .inte_val(bus.din[0]),
    .port_rd(rd && bus.addr == ADDR_PB), .port_wr(wr && bus.addr == ADDR_PB),
    .stb_n(pc_in[PC_STB_B]), .ack_n(pc_in[PC_ACK_B]), .port_in(pb_in),
    .in_latch(b_latch), .pc_val(b_pc_val), .pc_own(b_pc_own), .pc_inp(b_pc_inp)
  );

  // Handshake status overrides the PC latch; handshake inputs never drive
  assign pc_out = (pc_lat & ~(a_pc_own | b_pc_own)) | a_pc_val | b_pc_val;
  assign pc_oe  = (base_pc_oe & ~(a_pc_inp | b_pc_inp)) | a_pc_own | b_pc_own;
  assign pa_rd  = (a_mode == MODE1 && a_in) ? a_latch : ((pa_lat & pa_oe) | (pa_in & ~pa_oe));
  assign pb_rd  = (b_mode == MODE1 && b_in) ? b_latch : ((pb_lat & pb_oe) | (pb_in & ~pb_oe));
`else
  assign pc_out = pc_lat;
  assign pc_oe  = base_pc_oe;
  assign pa_rd  = (pa_lat & pa_oe) | (pa_in & ~pa_oe);
  assign pb_rd  = (pb_lat & pb_oe) | (pb_in & ~pb_oe);
`endif

  // Driven port C bits read back what is driven, the rest read the pins
  assign pc_rd = (pc_out & pc_oe) | (pc_in & ~pc_oe);

  // Read mux
  always_comb begin
    bus.dout = 8'h00;
    case (bus.addr)
      ADDR_PA: bus.dout = pa_rd;
      ADDR_PB: bus.dout = pb_rd;
      ADDR_PC: bus.dout = pc_rd;
      default: bus.dout = ctrl;
    endcase
  end
endmodule
